// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: access size encodings shared with the control decoder, plus FSM states
package mem_access_unit_pkg;
   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_WORD = 2'b01;
   localparam logic [1:0] MEM_BYTE = 2'b10;
   localparam logic [1:0] MEM_HALF = 2'b11;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store lane replication and load extract/sign-extend
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lo,
   input  logic [31:0] wd,
   input  logic [31:0] rd,
   output logic [3:0]  be,
   output logic [31:0] wrep,
   output logic [31:0] ld
);
   logic [31:0] sh;
   logic [15:0] h;
   always_comb begin
      sh   = rd >> {lo, 3'b000};
      h    = lo[1] ? rd[31:16] : rd[15:0];
      be   = size == MEM_BYTE ? 4'b0001 << lo :
             size == MEM_HALF ? (lo[1] ? 4'b1100 : 4'b0011) :
             size == MEM_WORD ? 4'b1111 : 4'b0000;
      wrep = size == MEM_BYTE ? {4{wd[7:0]}} :
             size == MEM_HALF ? {2{wd[15:0]}} : wd;
      ld   = size == MEM_BYTE ? {{24{sh[7]}}, sh[7:0]} :
             size == MEM_HALF ? {{16{h[15]}}, h} : rd;
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer with alignment checks and a single-word memory port
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [1:0]  mem_read,
   input  logic [1:0]  mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata
);
   state_t      state;
   logic [1:0]  size, req_size;
   logic        store, one_op, both_op, aligned, accept;
   logic [31:0] a, wd, ld;
   always_comb begin
      req_size = mem_read | mem_write;
      one_op   = (mem_read != MEM_NONE) ^ (mem_write != MEM_NONE);
      both_op  = (mem_read != MEM_NONE) && (mem_write != MEM_NONE);
      aligned  = req_size == MEM_WORD ? addr[1:0] == 2'b00 :
                 req_size == MEM_HALF ? !addr[0] : 1'b1;
      accept   = !reset && req_valid && state == S_IDLE && one_op && aligned;
      err      = !reset && req_valid && state == S_IDLE && (both_op || (one_op && !aligned));
   end
   assign stall   = accept || state == S_REQ;
   assign done    = state == S_DONE;
   assign dm_req  = state == S_REQ;
   assign dm_we   = dm_req && store;
   assign dm_addr = {a[31:2], 2'b00};
   // Lane logic works from latched request fields so the memory port stays stable while waiting
   mem_lane_align u_align (
      .size (size),
      .lo   (a[1:0]),
      .wd   (wd),
      .rd   (dm_rdata),
      .be   (dm_be),
      .wrep (dm_wdata),
      .ld   (ld)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         size  <= MEM_NONE;
         store <= 1'b0;
         a     <= '0;
         wd    <= '0;
         rdata <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               state <= S_REQ;
               size  <= req_size;
               store <= mem_write != MEM_NONE;
               a     <= addr;
               wd    <= wdata;
            end
            S_REQ: if (dm_ack) begin
               state <= S_DONE;
               if (!store) rdata <= ld;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store/error/reset sequence with an rdata scoreboard
module tb_mem_access_unit;
   logic        clk = 0, reset = 1, req_valid = 0, dm_ack = 0;
   logic [1:0]  mem_read = 0, mem_write = 0;
   logic [31:0] addr = 0, wdata = 0, dm_rdata = 0;
   logic        stall, done, err, dm_req, dm_we;
   logic [31:0] rdata, dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   int          errors = 0, checks = 0;
   logic [31:0] exp_q[$];

   mem_access_unit dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .mem_read(mem_read),
      .mem_write(mem_write), .addr(addr), .wdata(wdata), .stall(stall),
      .done(done), .rdata(rdata), .err(err), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
      .dm_rdata(dm_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic do_op(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [31:0] rw, input int waits,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
      @(posedge clk); #1;
      req_valid = 1; mem_read = rd; mem_write = wr; addr = ad; wdata = wd;
      exp_q.push_back(erd);
      @(negedge clk);
      chk("accept_stall", stall, 1); chk("accept_err", err, 0); chk("accept_req", dm_req, 0);
      @(posedge clk); #1;
      mem_read = 2'b01; addr = 32'h0; wdata = 32'hFFFF_FFFF;
      for (int i = 0; i <= waits; i++) begin
         dm_ack = (i == waits);
         dm_rdata = (i == waits) ? rw : 32'h5A5A_5A5A;
         @(negedge clk);
         chk("req", dm_req, 1); chk("req_stall", stall, 1); chk("req_done", done, 0);
         chk("be", dm_be, ebe); chk("wdata", dm_wdata, ewd); chk("we", dm_we, wr != 0);
         chk("addr", dm_addr, {ad[31:2], 2'b00});
         @(posedge clk); #1;
         req_valid = 0; mem_read = 0; mem_write = 0;
      end
      dm_ack = 0;
      @(negedge clk);
      chk("done", done, 1); chk("done_stall", stall, 0); chk("done_req", dm_req, 0);
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $error("FAIL scoreboard observed=empty expected=entry");
      end else chk("rdata", rdata, exp_q.pop_front());
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_pulse", done, 0);
   endtask

   task automatic bad(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] ad);
      @(posedge clk); #1;
      req_valid = 1; mem_read = rd; mem_write = wr; addr = ad;
      @(negedge clk);
      chk("err", err, 1); chk("err_stall", stall, 0); chk("err_req", dm_req, 0);
      @(posedge clk); #1;
      req_valid = 0; mem_read = 0; mem_write = 0;
      @(negedge clk);
      chk("err_pulse", err, 0); chk("err_idle_req", dm_req, 0); chk("err_idle_stall", stall, 0);
   endtask

   initial begin
      req_valid = 1; mem_read = 2'b01; addr = 32'h100;
      repeat (2) @(posedge clk);
      #1 reset = 0; req_valid = 0; mem_read = 0; addr = 0; dm_ack = 1;
      @(negedge clk);
      chk("rst_stall", stall, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
      chk("rst_req", dm_req, 0); chk("rst_we", dm_we, 0); chk("rst_be", dm_be, 0);
      chk("rst_rdata", rdata, 0); chk("rst_addr", dm_addr, 0); chk("rst_wdata", dm_wdata, 0);
      @(posedge clk); #1 dm_ack = 0;
      @(negedge clk);
      chk("idle_ack_done", done, 0); chk("idle_ack_req", dm_req, 0);

      do_op(2'b10, 2'b00, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
      do_op(2'b00, 2'b11, 32'h0000_2002, 32'h0000_1234, 32'hDEAD_BEEF, 3, 4'b1100, 32'h1234_1234, 32'hFFFF_FF80);
      do_op(2'b01, 2'b00, 32'h0000_3004, 32'h0, 32'h1234_5678, 1, 4'b1111, 32'h0, 32'h1234_5678);
      do_op(2'b11, 2'b00, 32'h0000_3000, 32'h0, 32'hABCD_8001, 0, 4'b0011, 32'h0, 32'hFFFF_8001);
      do_op(2'b11, 2'b00, 32'h0000_3002, 32'h0, 32'h7FFF_0000, 2, 4'b1100, 32'h0, 32'h0000_7FFF);
      do_op(2'b10, 2'b00, 32'h0000_1001, 32'h0, 32'h0000_7F00, 0, 4'b0010, 32'h0, 32'h0000_007F);
      do_op(2'b00, 2'b10, 32'h0000_1002, 32'hFFFF_FFA5, 32'h0, 1, 4'b0100, 32'hA5A5_A5A5, 32'h0000_007F);
      do_op(2'b00, 2'b01, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0000_007F);

      bad(2'b01, 2'b00, 32'h0000_3001);
      bad(2'b11, 2'b00, 32'h0000_3001);
      bad(2'b01, 2'b00, 32'h0000_3002);
      bad(2'b00, 2'b11, 32'h0000_2003);
      bad(2'b01, 2'b01, 32'h0000_0000);

      @(posedge clk); #1;
      req_valid = 1; mem_read = 2'b01; addr = 32'h0000_5000;
      @(posedge clk); #1;
      req_valid = 0; mem_read = 0; reset = 1;
      @(negedge clk);
      chk("mid_req_before_reset", dm_req, 1);
      @(posedge clk); #1;
      reset = 0; dm_ack = 1; dm_rdata = 32'h1111_1111;
      @(negedge clk);
      chk("mid_rst_req", dm_req, 0); chk("mid_rst_stall", stall, 0); chk("mid_rst_done", done, 0);
      @(posedge clk); #1 dm_ack = 0;
      @(negedge clk);
      chk("late_ack_done", done, 0); chk("late_ack_rdata", rdata, 0); chk("late_ack_be", dm_be, 0);
      @(negedge clk);
      chk("late_ack_done2", done, 0);

      do_op(2'b01, 2'b00, 32'h0000_6008, 32'h0, 32'h0BAD_CAFE, 1, 4'b1111, 32'h0, 32'h0BAD_CAFE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  MEM-stage instruction valid.
REQ-005 mem_read  input  2  load size from control decoder: 00 none, 01 word, 10 byte, 11 half.
REQ-006 mem_write  input  2  store size, same encoding as mem_read.
REQ-007 addr  input  32  byte address from ALU.
REQ-008 wdata  input  32  store data; low byte/half used for sb/sh.
REQ-009 stall  output  1  freeze upstream pipeline while access in flight.
REQ-010 done  output  1  one-cycle pulse; load result or store completion.
REQ-011 rdata  output  32  sign-extended load result; valid when done=1.
REQ-012 err  output  1  one-cycle pulse on misaligned or illegal request.
REQ-013 dm_req / dm_we  output  1 / 1  data-memory request and write strobe.
REQ-014 dm_addr  output  32  word-aligned address, addr with [1:0] forced to 00.
REQ-015 dm_be  output  4  byte enables, lane k = bits [8k+7:8k].
REQ-016 dm_wdata  output  32  lane-replicated store data.
REQ-017 dm_ack / dm_rdata  input  1 / 32  memory completion and read word.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DONE.
REQ-019 Accept: in IDLE, req_valid=1 with exactly one of mem_read/mem_write non-zero and address aligned latches op, addr, wdata and moves to REQ.
REQ-020 Alignment: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned.
REQ-021 Misaligned request, or both mem_read and mem_write non-zero, SHALL pulse err in the same cycle, stay in IDLE, issue no access, and hold stall=0.
REQ-022 REQ: dm_req=1 with dm_addr/dm_be/dm_we/dm_wdata stable until dm_ack=1; the ack edge captures dm_rdata and moves to DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 stall = (IDLE and accepting) or REQ; stall=0 in DONE.
REQ-025 Minimum latency: acceptance at edge t, ack in the first REQ cycle, done=1 in cycle t+2; each extra wait cycle adds one.
REQ-026 Byte enables: byte 1<<addr[1:0]; half 0011 if addr[1]=0 else 1100; word 1111.
REQ-027 Store data: byte replicated x4; half replicated x2; word as-is.
REQ-028 Load extraction: byte and half take the selected lane(s) and sign-extend to 32 bits; word is passed through.
REQ-029 req_valid/op changes outside IDLE SHALL be ignored.
REQ-030 dm_ack while not in REQ SHALL be ignored.
REQ-031 rdata holds its last value until the next load completes; store completion leaves rdata unchanged.

Reset
REQ-032 Reset SHALL force IDLE and stall=done=err=dm_req=dm_we=0, dm_be=0000, rdata=0, dm_addr=dm_wdata=0.
REQ-033 Reset mid-access SHALL drop dm_req on the next cycle, discard the operation, and produce no done.

Structure
REQ-034 The shared package SHALL hold the 2-bit size encodings MEM_NONE/MEM_WORD/MEM_BYTE/MEM_HALF, used by both the control decoder and this block, plus the FSM state encoding.
REQ-035 One combinational sub-module, mem_lane_align, SHALL compute dm_be, store replication and load extract/sign-extend; the FSM stays in mem_access_unit.

Verification
REQ-036 lb addr=0x1003, dm_rdata=0x80FF_FF00, ack in 1st REQ cycle -> dm_be=1000, done at t+2, rdata=0xFFFF_FF80.
REQ-037 sh addr=0x2002, wdata=0x0000_1234, ack after 3 waits -> dm_be=1100, dm_wdata=0x1234_1234, dm_we=1, stall for 5 cycles, done at t+5.
REQ-038 lw addr=0x3001 -> err pulse, dm_req never asserted, stall=0; lh addr=0x3001 -> err pulse.
REQ-039 mem_read=01 with mem_write=01 -> err pulse, no access.
REQ-040 Reset asserted in REQ with ack pending -> next cycle IDLE, dm_req=0; late ack ignored; no done pulse.
